cpu_lsu: RTL and testbench
==========================

// Module: cpu_lsu
// PURPOSE
//  Load/store unit for the next-generation core. Sits between the execute stage and the
//  data RAM. Replaces the single-cycle, always-ready dram_* path with a ready/valid request,
//  a req/ack memory handshake and a held response. Adds misalignment and timeout detection,
//  plus XLEN-generic lane alignment, including LD/SD when XLEN=64.
// PARAMETERS
//  XLEN     32    data/address width; legal values are 32 and 64
//  TIMEOUT  255   max BUSY cycles waiting for dram_ack_i (1..65535)
// PORTS
//  clk_i           in   1        clock
//  rst_i           in   1        reset, synchronous, active-high
//  req_valid_i     in   1        request from execute stage
//  req_ready_o     out  1        LSU can accept a request (state IDLE)
//  req_store_i     in   1        1=store, 0=load
//  req_funct3_i    in   3        RISC-V funct3: [1:0] size (B/H/W/D), [2] unsigned-load
//  req_addr_i      in   XLEN     byte address
//  req_wdata_i     in   XLEN     store data, LSB-justified
//  req_rd_i        in   5        destination register tag, echoed in the response
//  rsp_valid_o     out  1        response available
//  rsp_ready_i     in   1        consumer takes the response
//  rsp_rd_o        out  5        echoed tag
//  rsp_data_o      out  XLEN     load result, extended; 0 for stores and errors
//  rsp_err_o       out  2        0 OK, 1 misaligned, 2 timeout, 3 illegal size
//  dram_req_o      out  1        memory request, held until ack
//  dram_we_o       out  1        write strobe qualifier
//  dram_addr_o     out  XLEN     address aligned to XLEN/8 bytes
//  dram_wdata_o    out  XLEN     lane-shifted store data
//  dram_byte_en_o  out  XLEN/8   byte enables (reads: all enables of the accessed size)
//  dram_ack_i      in   1        memory completes the access this cycle
//  dram_rdata_i    in   XLEN     read data, valid with ack
// BEHAVIOUR
//  Reset values: all outputs 0 except req_ready_o=1; state=IDLE; timeout counter=0.
//  Reset mid-access drops dram_req_o at the next edge; a pending ack is ignored.
//  FSM states: IDLE, BUSY, RESP.
//   IDLE: req_ready_o=1. Accept on req_valid_i&req_ready_o and register every req_* field.
//    - illegal size (D when XLEN=32) -> RESP with err=3
//    - addr not size-aligned -> RESP with err=1
//    - in both error cases, no dram_req_o is issued
//    - otherwise -> BUSY
//   BUSY: dram_req_o=1; all dram_* outputs are stable until ack.
//    - ack -> RESP; capture the aligned and extended read data
//    - counter reaches TIMEOUT without ack -> RESP with err=2, dram_req_o deasserted
//    - ack and timeout in the same cycle: the ack wins (err=0)
//   RESP: rsp_valid_o=1; all rsp_* outputs are held until rsp_ready_i.
//    - on handshake -> IDLE; the next request is accepted one cycle later
//  Latency with zero-wait RAM (ack in the first BUSY cycle): accept at edge N;
//   dram_req_o high in cycle N+1; rsp_valid_o high in cycle N+2.
//  Lane alignment: off = addr[log2(XLEN/8)-1:0].
//   Store: wdata << 8*off; byte_en = size_mask << off.
//   Load: (rdata >> 8*off), truncated to size, then sign- or zero-extended to XLEN.
//   The timeout counter clears on entry to BUSY.
//  Back-to-back: no overlap; at most one request is outstanding.
// STRUCTURE
//  cpu_pkg: lsu_state_t {IDLE,BUSY,RESP}; lsu_err_t {ERR_OK,ERR_MISALIGN,ERR_TIMEOUT,
//   ERR_SIZE}; size constants SZ_B/SZ_H/SZ_W/SZ_D.
//  One sub-module, lsu_align (combinational):
//   - store lane shift and byte-enable generation
//   - load extract and extend
//   - misaligned and illegal-size flags
//  cpu_lsu holds the FSM, request registers, timeout counter and response registers.
// TESTING
//  1 SW 0xDEADBEEF @0x104, ack in 1st BUSY cycle -> byte_en=4'hF, addr=0x104, rsp err=0,
//    rsp_valid at accept+2.
//  2 SB 0x000000A5 @0x103 -> wdata=0xA5000000, byte_en=4'h8.
//    LB @0x103 with rdata=0x80xxxxxx -> rsp_data=0xFFFFFF80.
//    LBU @0x103 with the same rdata -> rsp_data=0x00000080.
//  3 LH @0x101 -> rsp err=1 the cycle after accept; dram_req_o never asserted; rsp_data=0.
//  4 TIMEOUT=4, no ack -> dram_req_o high 4 cycles, then rsp err=2;
//    a 2nd run with ack on the 4th cycle -> err=0.
//  5 rsp_ready_i low for 5 cycles -> rsp_* held stable and req_ready_o=0 throughout.
//  6 XLEN=64: SD @0x8 -> byte_en=8'hFF; LW @0x4 with rdata[63:32]=0x80000000
//    -> 0xFFFFFFFF80000000. XLEN=32: LD -> err=3.
//  7 rst_i pulsed during BUSY -> next edge: dram_req_o=0, req_ready_o=1, rsp_valid_o=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types for the load/store unit.
//   lsu_state_t : FSM encoding (IDLE, BUSY, RESP)
//   lsu_err_t   : response error codes carried on rsp_err_o
//   SZ_*        : funct3[1:0] access-size encodings
package cpu_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} lsu_state_t;

  typedef enum logic [1:0] {
    ERR_OK       = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_TIMEOUT  = 2'd2,
    ERR_SIZE     = 2'd3
  } lsu_err_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
endpackage

// File: rtl/lsu_align.sv
// Combinational lane alignment for the LSU.
//   funct3_i  : size [1:0], unsigned-load [2]
//   addr_lo_i : low three address bits (lane offset + alignment check)
//   wdata_i   : LSB-justified store data   -> wdata_o  : lane-shifted store data
//   rdata_i   : raw memory word            -> rdata_o  : extracted, extended load data
//   byte_en_o : size mask shifted into the addressed lanes
//   misalign_o: address not a multiple of the access size
//   bad_size_o: doubleword access on a 32-bit datapath
module lsu_align
  import cpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]        funct3_i,
  input  logic [2:0]        addr_lo_i,
  input  logic [XLEN-1:0]   wdata_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN-1:0]   wdata_o,
  output logic [XLEN/8-1:0] byte_en_o,
  output logic [XLEN-1:0]   rdata_o,
  output logic              misalign_o,
  output logic              bad_size_o
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  logic [1:0]      size;
  logic            sx;
  logic [OFFW-1:0] off;
  logic [7:0]      mask;
  logic [2:0]      alm;
  logic [XLEN-1:0] rsh;
  logic [63:0]     b_ext, h_ext, w_ext;

  assign size = funct3_i[1:0];
  assign sx   = ~funct3_i[2];
  assign off  = addr_lo_i[OFFW-1:0];

  always_comb begin
    mask = 8'hFF;
    alm  = 3'd7;
    unique case (size)
      SZ_B: begin mask = 8'h01; alm = 3'd0; end
      SZ_H: begin mask = 8'h03; alm = 3'd1; end
      SZ_W: begin mask = 8'h0F; alm = 3'd3; end
      default: begin mask = 8'hFF; alm = 3'd7; end
    endcase
  end

  assign byte_en_o  = NB'(mask) << off;
  assign wdata_o    = wdata_i << {off, 3'b000};
  assign misalign_o = |(addr_lo_i & alm);
  assign bad_size_o = (XLEN == 32) && (size == SZ_D);

  // Extensions are built at 64 bits and truncated so no replication count
  // ever goes to zero when XLEN=32.
  assign rsh   = rdata_i >> {off, 3'b000};
  assign b_ext = {{56{sx & rsh[7]}},  rsh[7:0]};
  assign h_ext = {{48{sx & rsh[15]}}, rsh[15:0]};
  assign w_ext = {{32{sx & rsh[31]}}, rsh[31:0]};

  always_comb begin
    rdata_o = rsh;
    unique case (size)
      SZ_B:    rdata_o = XLEN'(b_ext);
      SZ_H:    rdata_o = XLEN'(h_ext);
      SZ_W:    rdata_o = XLEN'(w_ext);
      default: rdata_o = rsh;
    endcase
  end
endmodule

// File: rtl/cpu_lsu.sv
// Load/store unit between execute and data RAM.
//   req_*  : ready/valid request from execute (accepted only in IDLE)
//   rsp_*  : held response (valid until rsp_ready_i), err 0/1/2/3
//   dram_* : req/ack memory handshake; outputs stable while dram_req_o is high
// Parameters: XLEN (32 or 64), TIMEOUT (max BUSY cycles without ack).
module cpu_lsu
  import cpu_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [XLEN-1:0]   req_addr_i,
  input  logic [XLEN-1:0]   req_wdata_i,
  input  logic [4:0]        req_rd_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [4:0]        rsp_rd_o,
  output logic [XLEN-1:0]   rsp_data_o,
  output logic [1:0]        rsp_err_o,
  output logic              dram_req_o,
  output logic              dram_we_o,
  output logic [XLEN-1:0]   dram_addr_o,
  output logic [XLEN-1:0]   dram_wdata_o,
  output logic [XLEN/8-1:0] dram_byte_en_o,
  input  logic              dram_ack_i,
  input  logic [XLEN-1:0]   dram_rdata_i
);
  localparam int NB   = XLEN / 8;
  localparam int OFFW = $clog2(NB);

  lsu_state_t      state_q, state_d;
  logic            store_q, store_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  lsu_err_t        rsp_err_q, rsp_err_d;
  logic            ready_q, ready_d;
  logic            dreq_q, dreq_d;
  logic            rvalid_q, rvalid_d;

  // In IDLE the aligner looks at the incoming request so the error checks
  // can steer the FSM at accept; afterwards it sees the held request.
  logic            idle;
  logic [2:0]      a_f3;
  logic [2:0]      a_addr_lo;
  logic [XLEN-1:0] a_wdata;
  logic [XLEN-1:0] al_wdata, al_rdata;
  logic [NB-1:0]   al_be;
  logic            misalign, bad_size;

  assign idle      = (state_q == IDLE);
  assign a_f3      = idle ? req_funct3_i : f3_q;
  assign a_addr_lo = idle ? req_addr_i[2:0] : addr_q[2:0];
  assign a_wdata   = idle ? req_wdata_i : wdata_q;

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3_i  (a_f3),
    .addr_lo_i (a_addr_lo),
    .wdata_i   (a_wdata),
    .rdata_i   (dram_rdata_i),
    .wdata_o   (al_wdata),
    .byte_en_o (al_be),
    .rdata_o   (al_rdata),
    .misalign_o(misalign),
    .bad_size_o(bad_size)
  );

  always_comb begin
    state_d    = state_q;
    store_d    = store_q;
    f3_d       = f3_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    ready_d    = ready_q;
    dreq_d     = dreq_q;
    rvalid_d   = rvalid_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i && ready_q) begin
          store_d    = req_store_i;
          f3_d       = req_funct3_i;
          addr_d     = req_addr_i;
          wdata_d    = req_wdata_i;
          rd_d       = req_rd_i;
          rsp_data_d = '0;
          ready_d    = 1'b0;
          if (bad_size || misalign) begin
            // Size error outranks misalignment: a D access is meaningless here.
            rsp_err_d = bad_size ? ERR_SIZE : ERR_MISALIGN;
            rvalid_d  = 1'b1;
            state_d   = RESP;
          end else begin
            rsp_err_d = ERR_OK;
            dreq_d    = 1'b1;
            cnt_d     = '0;
            state_d   = BUSY;
          end
        end
      end
      BUSY: begin
        // Ack is checked first so it wins over a coincident timeout.
        if (dram_ack_i) begin
          rsp_data_d = store_q ? '0 : al_rdata;
          rsp_err_d  = ERR_OK;
          dreq_d     = 1'b0;
          rvalid_d   = 1'b1;
          state_d    = RESP;
        end else if (cnt_q == 16'(TIMEOUT - 1)) begin
          rsp_data_d = '0;
          rsp_err_d  = ERR_TIMEOUT;
          dreq_d     = 1'b0;
          rvalid_d   = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          rsp_data_d = '0;
          rsp_err_d  = ERR_OK;
          rvalid_d   = 1'b0;
          ready_d    = 1'b1;
          state_d    = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        dreq_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      store_q    <= 1'b0;
      f3_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= ERR_OK;
      ready_q    <= 1'b1;
      dreq_q     <= 1'b0;
      rvalid_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      store_q    <= store_d;
      f3_q       <= f3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      ready_q    <= ready_d;
      dreq_q     <= dreq_d;
      rvalid_q   <= rvalid_d;
    end
  end

  assign req_ready_o    = ready_q;
  assign rsp_valid_o    = rvalid_q;
  assign rsp_rd_o       = rd_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  // Memory-side outputs read zero whenever no access is in flight.
  assign dram_req_o     = dreq_q;
  assign dram_we_o      = dreq_q & store_q;
  assign dram_addr_o    = dreq_q ? {addr_q[XLEN-1:OFFW], {OFFW{1'b0}}} : '0;
  assign dram_wdata_o   = dreq_q ? al_wdata : '0;
  assign dram_byte_en_o = dreq_q ? al_be : '0;
endmodule

// File: tb/tb_cpu_lsu.sv
module tb_cpu_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        v32, v64;
  logic        store;
  logic [2:0]  f3;
  logic [63:0] addr, wdata, rdata;
  logic [4:0]  rd;
  logic        rsp_ready, ack;
  bit          m64;
  int          total = 0;
  int          bad   = 0;

  logic        rdy32, rv32, dreq32, we32;
  logic [4:0]  rrd32;
  logic [31:0] rdat32, da32, dw32;
  logic [1:0]  err32;
  logic [3:0]  be32;
  logic        rdy64, rv64, dreq64, we64;
  logic [4:0]  rrd64;
  logic [63:0] rdat64, da64, dw64;
  logic [1:0]  err64;
  logic [7:0]  be64;

  always #5 clk = ~clk;

  cpu_lsu #(.XLEN(32), .TIMEOUT(4)) u32 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v32), .req_ready_o(rdy32),
    .req_store_i(store), .req_funct3_i(f3), .req_addr_i(addr[31:0]),
    .req_wdata_i(wdata[31:0]), .req_rd_i(rd), .rsp_valid_o(rv32),
    .rsp_ready_i(rsp_ready), .rsp_rd_o(rrd32), .rsp_data_o(rdat32),
    .rsp_err_o(err32), .dram_req_o(dreq32), .dram_we_o(we32),
    .dram_addr_o(da32), .dram_wdata_o(dw32), .dram_byte_en_o(be32),
    .dram_ack_i(ack), .dram_rdata_i(rdata[31:0]));

  cpu_lsu #(.XLEN(64), .TIMEOUT(4)) u64 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(v64), .req_ready_o(rdy64),
    .req_store_i(store), .req_funct3_i(f3), .req_addr_i(addr),
    .req_wdata_i(wdata), .req_rd_i(rd), .rsp_valid_o(rv64),
    .rsp_ready_i(rsp_ready), .rsp_rd_o(rrd64), .rsp_data_o(rdat64),
    .rsp_err_o(err64), .dram_req_o(dreq64), .dram_we_o(we64),
    .dram_addr_o(da64), .dram_wdata_o(dw64), .dram_byte_en_o(be64),
    .dram_ack_i(ack), .dram_rdata_i(rdata));

  // Observed view of whichever DUT is under test.
  logic        o_rdy, o_rv, o_dreq, o_we;
  logic [4:0]  o_rd;
  logic [1:0]  o_err;
  logic [63:0] o_data, o_da, o_dw;
  logic [7:0]  o_be;
  assign o_rdy  = m64 ? rdy64  : rdy32;
  assign o_rv   = m64 ? rv64   : rv32;
  assign o_dreq = m64 ? dreq64 : dreq32;
  assign o_we   = m64 ? we64   : we32;
  assign o_rd   = m64 ? rrd64  : rrd32;
  assign o_err  = m64 ? err64  : err32;
  assign o_data = m64 ? rdat64 : {32'b0, rdat32};
  assign o_da   = m64 ? da64   : {32'b0, da32};
  assign o_dw   = m64 ? dw64   : {32'b0, dw32};
  assign o_be   = m64 ? be64   : {4'b0, be32};

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic issue(bit st, logic [2:0] f, logic [63:0] a, logic [63:0] wd, logic [4:0] r);
    store = st; f3 = f; addr = a; wdata = wd; rd = r;
    if (m64) v64 = 1'b1; else v32 = 1'b1;
    @(posedge clk); #1;
    v32 = 1'b0; v64 = 1'b0;
  endtask

  task automatic ack_now(logic [63:0] d);
    ack = 1'b1; rdata = d;
    @(posedge clk); #1;
    ack = 1'b0;
  endtask

  task automatic take();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; v32 = 0; v64 = 0; store = 0; f3 = 0; addr = 0; wdata = 0;
    rdata = 0; rd = 0; rsp_ready = 0; ack = 0; m64 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", o_rdy, 1);
    chk("rst_rvalid", o_rv, 0);
    chk("rst_dreq", o_dreq, 0);
    chk("rst_be", o_be, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: SW, zero-wait ack
    issue(1, 3'b010, 64'h104, 64'hDEADBEEF, 5'd5);
    chk("sw_dreq", o_dreq, 1);
    chk("sw_we", o_we, 1);
    chk("sw_addr", o_da, 64'h104);
    chk("sw_be", o_be, 8'hF);
    chk("sw_wdata", o_dw, 64'hDEADBEEF);
    chk("sw_ready", o_rdy, 0);
    chk("sw_rv_early", o_rv, 0);
    ack_now(64'h0);
    chk("sw_rv", o_rv, 1);
    chk("sw_err", o_err, 0);
    chk("sw_rd", o_rd, 5);
    chk("sw_data", o_data, 0);
    chk("sw_dreq_off", o_dreq, 0);
    take();
    chk("sw_idle", o_rdy, 1);

    // 2: byte lanes
    issue(1, 3'b000, 64'h103, 64'hA5, 5'd1);
    chk("sb_wdata", o_dw, 64'hA5000000);
    chk("sb_be", o_be, 8'h8);
    chk("sb_addr", o_da, 64'h100);
    ack_now(64'h0); take();
    issue(0, 3'b000, 64'h103, 64'h0, 5'd2);
    chk("lb_we", o_we, 0);
    chk("lb_be", o_be, 8'h8);
    ack_now(64'h80123456);
    chk("lb_data", o_data, 64'hFFFFFF80);
    take();
    issue(0, 3'b100, 64'h103, 64'h0, 5'd3);
    ack_now(64'h80123456);
    chk("lbu_data", o_data, 64'h80);
    take();
    issue(0, 3'b001, 64'h102, 64'h0, 5'd4);
    chk("lh_be", o_be, 8'hC);
    ack_now(64'h80011234);
    chk("lh_data", o_data, 64'hFFFF8001);
    take();
    issue(0, 3'b101, 64'h102, 64'h0, 5'd4);
    ack_now(64'h80011234);
    chk("lhu_data", o_data, 64'h8001);
    take();

    // 3: misaligned halfword
    issue(0, 3'b001, 64'h101, 64'h0, 5'd6);
    chk("mis_rv", o_rv, 1);
    chk("mis_err", o_err, 1);
    chk("mis_dreq", o_dreq, 0);
    chk("mis_data", o_data, 0);
    take();

    // 4: timeout, then ack on the last allowed cycle
    issue(0, 3'b010, 64'h200, 64'h0, 5'd7);
    for (int i = 0; i < 4; i++) begin
      chk("to_dreq_hi", o_dreq, 1);
      @(posedge clk); #1;
    end
    chk("to_rv", o_rv, 1);
    chk("to_err", o_err, 2);
    chk("to_dreq_lo", o_dreq, 0);
    take();
    issue(0, 3'b010, 64'h200, 64'h0, 5'd7);
    repeat (3) begin @(posedge clk); #1; end
    chk("to4_dreq", o_dreq, 1);
    ack_now(64'h12345678);
    chk("to4_err", o_err, 0);
    chk("to4_data", o_data, 64'h12345678);
    take();

    // 5: response back-pressure
    issue(0, 3'b010, 64'h10, 64'h0, 5'd9);
    ack_now(64'hCAFEF00D);
    for (int i = 0; i < 5; i++) begin
      chk("hold_rv", o_rv, 1);
      chk("hold_data", o_data, 64'hCAFEF00D);
      chk("hold_rd", o_rd, 9);
      chk("hold_ready", o_rdy, 0);
      @(posedge clk); #1;
    end
    take();
    chk("hold_release", o_rv, 0);

    // 6: illegal doubleword on 32-bit
    issue(0, 3'b011, 64'h8, 64'h0, 5'd10);
    chk("ld32_err", o_err, 3);
    chk("ld32_dreq", o_dreq, 0);
    take();

    // 6: 64-bit lanes
    m64 = 1;
    issue(1, 3'b011, 64'h8, 64'h1122334455667788, 5'd11);
    chk("sd_be", o_be, 8'hFF);
    chk("sd_addr", o_da, 64'h8);
    chk("sd_wdata", o_dw, 64'h1122334455667788);
    ack_now(64'h0); take();
    issue(0, 3'b010, 64'h4, 64'h0, 5'd12);
    chk("lw64_be", o_be, 8'hF0);
    ack_now(64'h80000000_00000000);
    chk("lw64_data", o_data, 64'hFFFFFFFF80000000);
    take();
    issue(0, 3'b110, 64'h4, 64'h0, 5'd12);
    ack_now(64'h80000000_00000000);
    chk("lwu64_data", o_data, 64'h0000000080000000);
    take();
    issue(1, 3'b000, 64'hD, 64'hA5, 5'd13);
    chk("sb64_be", o_be, 8'h20);
    chk("sb64_wdata", o_dw, 64'h0000A50000000000);
    ack_now(64'h0); take();
    m64 = 0;

    // 7: reset during BUSY with a coincident ack
    issue(1, 3'b010, 64'h40, 64'h1, 5'd14);
    chk("rb_busy", o_dreq, 1);
    rst = 1'b1; ack = 1'b1;
    @(posedge clk); #1;
    chk("rb_dreq", o_dreq, 0);
    chk("rb_ready", o_rdy, 1);
    chk("rb_rv", o_rv, 0);
    rst = 1'b0; ack = 1'b0;
    @(posedge clk); #1;
    chk("rb_rv_after", o_rv, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
